// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 4;
    localparam int DEF_CNT_W               = 16;
    localparam int RELOCK_W                = 8;

    typedef struct packed {
        logic pll_rst;
        logic video_rst;
        logic ready;
        logic fault;
    } seq_out_t;

    // Output levels that belong to a given state; the PLL is held in reset
    // everywhere except while waiting for or holding lock.
    function automatic seq_out_t decode_out(input state_t s);
        seq_out_t o;
        o.pll_rst   = 1'b1;
        o.video_rst = 1'b1;
        o.ready     = 1'b0;
        o.fault     = 1'b0;
        case (s)
            WAIT_LOCK, STABLE: o.pll_rst = 1'b0;
            RUN: begin
                o.pll_rst   = 1'b0;
                o.video_rst = 1'b0;
                o.ready     = 1'b1;
            end
            FAULT:   o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic two-flop bit synchroniser, async active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock, releases the
// video reset, retries on timeout and latches a fault after repeated failures.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLL_RST   | PLL reset pulse being driven
// WAIT_LOCK | PLL out of reset, waiting for synchronised lock (timed)
// STABLE    | lock seen, counting consecutive locked cycles
// RUN       | lock qualified, video reset released
// FAULT     | too many consecutive timeouts, PLL held in reset
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                retry,
    output logic                pll_rst,
    output logic                video_rst,
    output logic                ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_LIMIT   = RET_W'(MAX_RETRIES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RET_W-1:0] retries;
    logic [RET_W-1:0] retries_inc;
    seq_out_t         outs;
    logic             lock_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    assign retries_inc = retries + RET_W'(1);

    assign pll_rst   = outs.pll_rst;
    assign video_rst = outs.video_rst;
    assign ready     = outs.ready;
    assign fault     = outs.fault;

    // Sequencer; outputs are registered from the state being entered so they
    // change on the same edge as the state itself.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state        <= PLL_RST;
            cnt          <= '0;
            retries      <= '0;
            outs         <= decode_out(PLL_RST);
            relock_count <= '0;
        end else begin
            outs <= decode_out(state);
            cnt  <= cnt + CNT_W'(1);
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        outs  <= decode_out(WAIT_LOCK);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                        outs  <= decode_out(STABLE);
                    end else if (cnt == TIMEOUT_LAST) begin
                        retries <= retries_inc;
                        cnt     <= '0;
                        if (retries_inc == RET_LIMIT) begin
                            state <= FAULT;
                            outs  <= decode_out(FAULT);
                        end else begin
                            state <= PLL_RST;
                            outs  <= decode_out(PLL_RST);
                        end
                    end
                end
                STABLE: begin
                    // A dropout here is a glitch: restart the wait, keep retries.
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        outs  <= decode_out(WAIT_LOCK);
                    end else if (cnt == STABLE_LAST) begin
                        state   <= RUN;
                        cnt     <= '0;
                        retries <= '0;
                        outs    <= decode_out(RUN);
                    end
                end
                RUN: begin
                    cnt <= '0;
                    if (!lock_s) begin
                        state <= PLL_RST;
                        outs  <= decode_out(PLL_RST);
                        if (relock_count != '1) begin
                            relock_count <= relock_count + RELOCK_W'(1);
                        end
                    end
                end
                FAULT: begin
                    cnt <= '0;
                    if (retry) begin
                        state   <= PLL_RST;
                        retries <= '0;
                        outs    <= decode_out(PLL_RST);
                    end
                end
                default: begin
                    state   <= PLL_RST;
                    cnt     <= '0;
                    retries <= '0;
                    outs    <= decode_out(PLL_RST);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small cycle parameters.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       retry;
    logic       pll_rst;
    logic       video_rst;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .CNT_W               (16)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .retry        (retry),
        .pll_rst      (pll_rst),
        .video_rst    (video_rst),
        .ready        (ready),
        .fault        (fault),
        .relock_count (relock_count)
    );

    always #5 refclk = ~refclk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, leaving time 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_val({tag, "_pll_rst"},   pll_rst,      1);
        chk_val({tag, "_video_rst"}, video_rst,    1);
        chk_val({tag, "_ready"},     ready,        0);
        chk_val({tag, "_fault"},     fault,        0);
        chk_val({tag, "_relock"},    relock_count, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        retry      = 1'b0;
        tick(3);
        chk_reset_vals("reset");

        // power-up: 4-cycle PLL reset pulse, lock at release+10
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk_val("pup_pll_rst_hi", pll_rst, 1);
        end
        tick(1);
        chk_val("pup_pll_rst_lo", pll_rst, 0);
        chk_val("pup_video_rst", video_rst, 1);
        tick(6);
        pll_locked = 1'b1;
        tick(10);
        chk_val("pup_ready_early", ready, 0);
        tick(1);
        chk_val("pup_ready", ready, 1);
        chk_val("pup_video_rel", video_rst, 0);
        chk_val("pup_relock", relock_count, 0);

        // retry ignored in RUN
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        tick(5);
        chk_val("run_retry_ready", ready, 1);
        chk_val("run_retry_pll_rst", pll_rst, 0);

        // lock loss in RUN
        pll_locked = 1'b0;
        tick(2);
        chk_val("loss_ready_held", ready, 1);
        tick(1);
        chk_val("loss_ready", ready, 0);
        chk_val("loss_video_rst", video_rst, 1);
        chk_val("loss_pll_rst", pll_rst, 1);
        chk_val("loss_relock", relock_count, 1);
        tick(3);
        chk_val("loss_pulse_hi", pll_rst, 1);
        tick(1);
        chk_val("loss_pulse_lo", pll_rst, 0);

        // retry ignored in WAIT_LOCK
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        chk_val("wait_retry_pll_rst", pll_rst, 0);
        tick(5);
        chk_val("wait_retry_pll_rst2", pll_rst, 0);
        chk_val("wait_retry_fault", fault, 0);
        pll_locked = 1'b1;
        tick(10);
        chk_val("relock_ready_early", ready, 0);
        tick(1);
        chk_val("relock_ready", ready, 1);

        // saturate relock_count over 300 losses
        for (int i = 2; i <= 300; i++) begin
            pll_locked = 1'b0;
            tick(7);
            pll_locked = 1'b1;
            tick(11);
            if (i == 254) chk_val("relock_254", relock_count, 254);
        end
        chk_val("relock_sat", relock_count, 255);
        chk_val("relock_sat_ready", ready, 1);

        // STABLE glitch at count 5, then recover
        pll_locked = 1'b0;
        tick(7);
        pll_locked = 1'b1;
        tick(8);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        chk_val("glitch_ready", ready, 0);
        tick(8);
        chk_val("glitch_ready_early", ready, 0);
        tick(1);
        chk_val("glitch_ready_run", ready, 1);

        // STABLE glitch then lock lost: still two full timeouts to fault
        pll_locked = 1'b0;
        tick(7);
        pll_locked = 1'b1;
        tick(8);
        pll_locked = 1'b0;
        tick(3);
        chk_val("glb_ready", ready, 0);
        tick(20);
        chk_val("to1_fault", fault, 0);
        chk_val("to1_pll_rst", pll_rst, 1);
        tick(3);
        chk_val("to1_pulse_hi", pll_rst, 1);
        tick(1);
        chk_val("to1_pulse_lo", pll_rst, 0);
        tick(19);
        chk_val("to2_fault_early", fault, 0);
        chk_val("to2_pll_rst_early", pll_rst, 0);
        tick(1);
        chk_val("to2_fault", fault, 1);
        chk_val("to2_pll_rst", pll_rst, 1);
        chk_val("to2_ready", ready, 0);
        chk_val("to2_video_rst", video_rst, 1);
        tick(30);
        chk_val("fault_hold", fault, 1);
        chk_val("fault_hold_pll_rst", pll_rst, 1);
        chk_val("fault_relock", relock_count, 255);

        // retry from FAULT
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        chk_val("retry_fault", fault, 0);
        chk_val("retry_pll_rst", pll_rst, 1);
        tick(3);
        chk_val("retry_pulse_hi", pll_rst, 1);
        tick(1);
        chk_val("retry_pulse_lo", pll_rst, 0);
        chk_val("retry_relock", relock_count, 255);
        tick(44);
        chk_val("refault", fault, 1);

        // async reset mid-FAULT
        rst = 1'b1;
        #1;
        chk_reset_vals("arst_fault");
        pll_locked = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk_val("ar1_pulse_hi", pll_rst, 1);
        tick(1);
        chk_val("ar1_pulse_lo", pll_rst, 0);
        tick(4);
        chk_val("ar1_stable_pll_rst", pll_rst, 0);
        chk_val("ar1_stable_ready", ready, 0);

        // async reset mid-STABLE
        rst = 1'b1;
        #1;
        chk_reset_vals("arst_stable");
        tick(2);
        rst = 1'b0;
        tick(4);
        chk_val("ar2_pulse_lo", pll_rst, 0);
        tick(8);
        chk_val("ar2_ready_early", ready, 0);
        tick(1);
        chk_val("ar2_ready", ready, 1);
        chk_val("ar2_video_rst", video_rst, 0);
        chk_val("ar2_relock", relock_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
